// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: 640x480@60 VGA timing, frame-buffer read addressing, pixel/sync alignment.
// Latency: RAM_LAT+1 cycles from scan counters to every output pin (sync, blank, rgb, frame_start).
// Backpressure: none; the pixel clock free-runs and enable=0 only parks the scan at (0,0).
//
// Ports:
//   vga_clk, reset   pixel clock; synchronous active-high reset
//   enable           1 = scan, 0 = counters held at 0 and idle values pushed down the pipe
//   mem_addr         frame-buffer port-B read address (combinational from the counters)
//   mem_q            port-B read data, valid RAM_LAT cycles after mem_addr; pixel in [7:0]
//   hsync, vsync     active-low syncs
//   blank_n          1 during visible pixels
//   red/green/blue   8-bit grey replicated to all three channels, black outside the window
//   frame_start      one-cycle pulse coincident with pixel (0,0) on the pins
module vga_frame_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int X_OFF    = 192,
  parameter int Y_OFF    = 112,
  parameter int RAM_LAT  = 2,
  parameter int AW       = 16
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          enable,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_q,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int WB      = $clog2(IMG_W);   // column bits of the frame-buffer address
  localparam int VRW     = AW - WB;         // row bits of the frame-buffer address

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] X_BEG  = HW'(X_OFF);
  localparam logic [HW-1:0] X_END  = HW'(X_OFF + IMG_W);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y_BEG  = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_END  = VW'(Y_OFF + IMG_H);

  // Illegal configurations are rejected at elaboration.
  if (X_OFF + IMG_W > H_ACTIVE || Y_OFF + IMG_H > V_ACTIVE) begin : g_chk_window
    $error("vga_frame_scanner: image window does not fit inside the active area");
  end
  if (IMG_W < 2 || (IMG_W & (IMG_W - 1)) != 0) begin : g_chk_img_w
    $error("vga_frame_scanner: IMG_W must be a power of two >= 2");
  end
  if (IMG_W * IMG_H > 2 ** AW) begin : g_chk_aw
    $error("vga_frame_scanner: AW too narrow for IMG_W*IMG_H");
  end
  if (RAM_LAT < 1) begin : g_chk_lat
    $error("vga_frame_scanner: RAM_LAT must be at least 1");
  end

  // Per-pixel control bits that travel alongside the RAM read.
  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
    logic in_win;
    logic sof;
  } scan_t;

  localparam scan_t SCAN_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, in_win: 1'b0, sof: 1'b0};

  // ---------------------------------------------------------------- counters
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // ---------------------------------------------------------------- stage-0 decode
  logic           in_win;
  logic [WB-1:0]  h_rel;
  logic [VRW-1:0] v_rel;
  scan_t          stage0;

  assign in_win = (h_cnt_q >= X_BEG) && (h_cnt_q < X_END) &&
                  (v_cnt_q >= Y_BEG) && (v_cnt_q < Y_END);

  // IMG_W is a power of two, so row*IMG_W + col is just {row, col}.
  assign h_rel    = WB'(h_cnt_q - X_BEG);
  assign v_rel    = VRW'(v_cnt_q - Y_BEG);
  assign mem_addr = in_win ? {v_rel, h_rel} : '0;

  // While disabled the pipe is fed idle values so the pins drain to black/no-sync.
  always_comb begin
    stage0 = SCAN_IDLE;
    if (enable) begin
      stage0.active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      stage0.hs_n   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
      stage0.vs_n   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
      stage0.in_win = in_win;
      stage0.sof    = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // ---------------------------------------------------------------- RAM-latency delay line
  scan_t pipe_q [RAM_LAT];
  scan_t pipe_d [RAM_LAT];

  always_comb begin
    pipe_d[0] = stage0;
    for (int i = 1; i < RAM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_LAT; i++) begin
        pipe_q[i] <= SCAN_IDLE;
      end
    end else begin
      for (int i = 0; i < RAM_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // ---------------------------------------------------------------- output register
  // The tail of the delay line lines up with mem_q for the same pixel.
  scan_t       tail;
  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q, blank_n_q, frame_start_q;
  logic        unused_mem_hi;

  assign tail          = pipe_q[RAM_LAT-1];
  assign rgb_d         = (tail.active && tail.in_win) ? {3{mem_q[7:0]}} : 24'h0;
  assign unused_mem_hi = ^mem_q[31:8];

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      hsync_q       <= tail.hs_n;
      vsync_q       <= tail.vs_n;
      blank_n_q     <= tail.active;
      frame_start_q <= tail.sof;
    end
  end

  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign frame_start = frame_start_q;

endmodule
